// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host-side handshake bundle for uart_tx_fifo
//
// Signals:
//   i_fTx     write strobe from host, pushes i_Data when o_fReady = 1
//   i_Data    DATA_BITS-wide word to send, LSB first
//   o_fReady  transmitter FIFO not full
//   o_fBusy   frame in progress or words still queued
//   o_fDone   one-cycle pulse in the last cycle of each frame
//   o_Tx      serial line, idle high
// Modports: master = host logic, slave = transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_fTx;
  logic [DATA_BITS-1:0] i_Data;
  logic                 o_fReady;
  logic                 o_fBusy;
  logic                 o_fDone;
  logic                 o_Tx;

  modport master (
    output i_fTx,
    output i_Data,
    input  o_fReady,
    input  o_fBusy,
    input  o_fDone,
    input  o_Tx
  );

  modport slave (
    input  i_fTx,
    input  i_Data,
    output o_fReady,
    output o_fBusy,
    output o_fDone,
    output o_Tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter with input FIFO
//
// Ports:
//   i_Clk  system clock, rising edge
//   i_Rst  asynchronous active-low reset
//   bus    uart_tx_fifo_if.slave: i_fTx/i_Data in, o_fReady/o_fBusy/o_fDone/o_Tx out
// Frames are start + DATA_BITS + optional parity + STOP_BITS, each bit DIV
// clocks long. Queued words are sent back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  uart_tx_fifo_if.slave bus
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic             PAR_INV   = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W:0]       count_q;
  logic [PTR_W:0]       count_d;
  logic                 ready_q;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  // Transmit datapath
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done;
  logic                 tick;

  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];
  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push       = bus.i_fTx & ready_q;
  assign tick       = (baud_q == BAUD_LAST);

  // Next-state and datapath decisions
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ PAR_INV;
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (tick) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_PAR: begin
        if (tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (tick) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            done  = 1'b1;
            bit_d = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ PAR_INV;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The line register follows the state being entered, so o_Tx changes
    // on the same edge as the state.
    tx_d = 1'b1;
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      ST_PAR:   tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      ready_q <= (count_d < DEPTH_C);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: count_q alone decides which entries are valid.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.i_Data;
    end
  end

  assign bus.o_Tx     = tx_q;
  assign bus.o_fReady = ready_q;
  assign bus.o_fBusy  = (state_q != ST_IDLE) | ~fifo_empty;
  assign bus.o_fDone  = done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_c ();
  uart_tx_fifo_if #(.DATA_BITS(5)) if_d ();

  uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.i_Clk(clk), .i_Rst(rst_n), .bus(if_a));
  uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_b (.i_Clk(clk), .i_Rst(rst_n), .bus(if_b));
  uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_c (.i_Clk(clk), .i_Rst(rst_n), .bus(if_c));
  uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_d (.i_Clk(clk), .i_Rst(rst_n), .bus(if_d));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int s);
    case (s)
      0:       return if_a.o_Tx;
      1:       return if_b.o_Tx;
      2:       return if_c.o_Tx;
      default: return if_d.o_Tx;
    endcase
  endfunction

  function automatic logic done_of(input int s);
    case (s)
      0:       return if_a.o_fDone;
      1:       return if_b.o_fDone;
      2:       return if_c.o_fDone;
      default: return if_d.o_fDone;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0:       return if_a.o_fBusy;
      1:       return if_b.o_fBusy;
      2:       return if_c.o_fBusy;
      default: return if_d.o_fBusy;
    endcase
  endfunction

  task automatic drive(input int s, input logic v, input logic [8:0] d);
    case (s)
      0:       begin if_a.i_fTx = v; if_a.i_Data = d[7:0]; end
      1:       begin if_b.i_fTx = v; if_b.i_Data = d[7:0]; end
      2:       begin if_c.i_fTx = v; if_c.i_Data = d[7:0]; end
      default: begin if_d.i_fTx = v; if_d.i_Data = d[4:0]; end
    endcase
  endtask

  // Line logger: one entry per falling edge while enabled.
  // Entry 0 is the cycle the first write is set up, so a frame starts at entry 2.
  logic       log_tx   [2048];
  logic       log_done [2048];
  int         log_n   = 0;
  bit         log_en  = 1'b0;
  int         log_sel = 0;
  logic [11:0] exp_vec [5];

  always @(negedge clk) begin
    if (log_en && log_n < 2048) begin
      log_tx[log_n]   = tx_of(log_sel);
      log_done[log_n] = done_of(log_sel);
      log_n++;
    end
  end

  // exp_vec[f] holds frame f's line values, slot 0 (start bit) in bit 0.
  task automatic check_log(input string tag, input int nframes, input int nslots);
    int flen     = nslots * 16;
    int last     = 2 + nframes * flen;
    int bad      = 0;
    int bad_done = 0;
    int n_done   = 0;
    int first0   = -1;
    for (int i = 0; i < log_n; i++) begin
      logic exp_tx;
      logic exp_dn;
      if (i < 2 || i >= last) begin
        exp_tx = 1'b1;
        exp_dn = 1'b0;
      end else begin
        exp_tx = exp_vec[(i - 2) / flen][((i - 2) % flen) / 16];
        exp_dn = (((i - 2) % flen) == flen - 1);
      end
      if (log_tx[i] !== exp_tx) bad++;
      if (log_done[i] !== exp_dn) bad_done++;
      if (log_done[i] === 1'b1) n_done++;
      if (first0 < 0 && log_tx[i] === 1'b0) first0 = i;
    end
    check({tag, "_latency"}, first0, 2);
    check({tag, "_line"}, bad, 0);
    check({tag, "_done_pos"}, bad_done, 0);
    check({tag, "_done_cnt"}, n_done, nframes);
  endtask

  task automatic single_frame(input string tag, input int s, input logic [8:0] word,
                              input logic [11:0] vec, input int nslots);
    @(posedge clk);
    log_n = 0; log_sel = s; log_en = 1'b1;
    @(negedge clk); drive(s, 1'b1, word);
    @(negedge clk); drive(s, 1'b0, word);
    repeat (nslots * 16 + 10) @(negedge clk);
    @(posedge clk);
    log_en = 1'b0;
    exp_vec[0] = vec;
    check_log(tag, 1, nslots);
    @(negedge clk);
    check({tag, "_tx_idle"}, tx_of(s), 1);
    check({tag, "_busy_idle"}, busy_of(s), 0);
  endtask

  initial begin
    int zeros;
    int k;
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 9'h0);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", if_a.o_Tx, 1);
    check("rst_ready", if_a.o_fReady, 1);
    check("rst_busy", if_a.o_fBusy, 0);
    check("rst_done", if_a.o_fDone, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frames; line vectors hand-derived, slot 0 = start bit
    single_frame("a_8n1", 0, 9'hA5, 12'h34A, 10); // 0,1,0,1,0,0,1,0,1,1
    single_frame("b_8e1", 1, 9'hA5, 12'h54A, 11); // parity slot 9 = 0
    single_frame("c_8o2", 2, 9'hA5, 12'hF4A, 12); // parity slot 9 = 1, two stops
    single_frame("d_5n1", 3, 9'h13, 12'h066, 7);  // 0,1,1,0,0,1,1

    // Burst of 5 writes, then a 6th while full
    @(posedge clk);
    log_n = 0; log_sel = 0; log_en = 1'b1;
    @(negedge clk); drive(0, 1'b1, 9'h01);
    @(negedge clk); check("burst_ready_w1", if_a.o_fReady, 1); drive(0, 1'b1, 9'h02);
    @(negedge clk); check("burst_ready_pop", if_a.o_fReady, 1); drive(0, 1'b1, 9'h03);
    @(negedge clk); drive(0, 1'b1, 9'h04);
    @(negedge clk); drive(0, 1'b1, 9'h05);
    @(negedge clk); check("burst_full", if_a.o_fReady, 0); drive(0, 1'b1, 9'h06);
    @(negedge clk); drive(0, 1'b0, 9'h00);
    check("burst_drop_ready", if_a.o_fReady, 0);
    repeat (820) @(negedge clk);
    @(posedge clk);
    log_en = 1'b0;
    for (int f = 0; f < 5; f++) exp_vec[f] = {2'b00, 1'b1, 8'(f + 1), 1'b0};
    check_log("burst", 5, 10);
    @(negedge clk);
    check("burst_busy_end", if_a.o_fBusy, 0);

    // Reset at cycle 40 of a frame with two words queued
    @(negedge clk); drive(0, 1'b1, 9'h11);
    @(negedge clk); drive(0, 1'b1, 9'h22);
    @(negedge clk); drive(0, 1'b1, 9'h33); // frame cycle 1
    @(negedge clk); drive(0, 1'b0, 9'h00); // frame cycle 2
    repeat (38) @(negedge clk);            // frame cycle 40, data bit 1 of 0x11
    check("rst_mid_pre_tx", if_a.o_Tx, 0);
    check("rst_mid_pre_busy", if_a.o_fBusy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", if_a.o_Tx, 1);
    check("rst_mid_ready", if_a.o_fReady, 1);
    check("rst_mid_busy", if_a.o_fBusy, 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    zeros = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (if_a.o_Tx !== 1'b1) zeros++;
    end
    check("rst_after_silent", zeros, 0);
    check("rst_after_busy", if_a.o_fBusy, 0);

    // Push and pop in the same cycle with DEPTH-1 words queued
    @(posedge clk);
    log_n = 0; log_sel = 0; log_en = 1'b1;
    @(negedge clk); drive(0, 1'b1, 9'h31);
    @(negedge clk); drive(0, 1'b1, 9'h32);
    @(negedge clk); drive(0, 1'b1, 9'h33);
    @(negedge clk); drive(0, 1'b1, 9'h34);
    @(negedge clk); drive(0, 1'b0, 9'h00);
    k = 0;
    while (if_a.o_fDone !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("pp_done_seen", if_a.o_fDone, 1);
    check("pp_count_pre", dut_a.count_q, 3);
    drive(0, 1'b1, 9'h35);
    @(negedge clk); drive(0, 1'b0, 9'h00);
    check("pp_count_post", dut_a.count_q, 3);
    check("pp_ready_post", if_a.o_fReady, 1);
    repeat (660) @(negedge clk);
    @(posedge clk);
    log_en = 1'b0;
    for (int f = 0; f < 5; f++) exp_vec[f] = {2'b00, 1'b1, 8'(8'h31 + f), 1'b0};
    check_log("pp", 5, 10);
    @(negedge clk);
    check("pp_busy_end", if_a.o_fBusy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
